// File: rtl/imm_gen_pkg.sv
// ============================================================================
// Module : imm_gen_pkg
// Brief  : Format codes, opcodes and decode/extend helpers for imm_gen_pipe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_SH  = 3'd6,
      FMT_ILL = 3'd7
   } imm_fmt_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;

   function automatic imm_fmt_t decode_fmt(input logic [31:0] inst, input logic xlen64);
      imm_fmt_t fmt;
      logic     is_shift;
      is_shift = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);
      case (inst[6:0])
         OP_OP:                        fmt = FMT_R;
         OP_IMM:                       fmt = is_shift ? FMT_SH : FMT_I;
         OP_LOAD, OP_JALR, OP_SYSTEM:  fmt = FMT_I;
         OP_STORE:                     fmt = FMT_S;
         OP_BRANCH:                    fmt = FMT_B;
         OP_LUI, OP_AUIPC:             fmt = FMT_U;
         OP_JAL:                       fmt = FMT_J;
         // Word-sized opcodes only exist on RV64.
         OP_IMM32:                     fmt = xlen64 ? (is_shift ? FMT_SH : FMT_I) : FMT_ILL;
         OP_OP32:                      fmt = xlen64 ? FMT_R : FMT_ILL;
         default:                      fmt = FMT_ILL;
      endcase
      return fmt;
   endfunction

   // Result is always 64 bits; narrower datapaths keep the low XLEN bits.
   function automatic logic [63:0] extend_imm(input logic [31:0] inst, input imm_fmt_t fmt,
                                              input logic xlen64);
      logic [63:0] imm;
      case (fmt)
         FMT_I:   imm = {{52{inst[31]}}, inst[31:20]};
         FMT_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_J:   imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         FMT_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
         FMT_SH: begin
            if (xlen64 && (inst[6:0] != OP_IMM32)) begin
               imm = {58'b0, inst[25:20]};
            end else begin
               imm = {59'b0, inst[24:20]};
            end
         end
         default: imm = 64'b0;
      endcase
      return imm;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module : pipe_stage_reg
// Brief  : One valid/ready register slice; accepts when empty or draining.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   assign in_ready  = !r_valid || out_ready;
   assign out_valid = r_valid;
   assign out_data  = r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (in_ready) begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_data <= in_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module : imm_gen_pipe
// Brief  : Pipelined RV32I/RV64I immediate generator with valid/ready flow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic [2:0]       fmt_out,
   output logic             illegal_out,
   output logic [TAG_W-1:0] tag_out
);

   localparam logic c_XLEN64 = (XLEN == 64);
   // Result payload layout: {imm, fmt, illegal, tag}
   localparam int   c_RES_W  = XLEN + 3 + 1 + TAG_W;
   // First-stage payload layout: {inst, tag, fmt}
   localparam int   c_S0_W   = 32 + TAG_W + 3;

   logic [c_RES_W-1:0] w_res_out;

   generate
      if (PIPE_STAGES == 1) begin : g_one_stage
         imm_fmt_t           w_fmt;
         logic [63:0]        w_imm64;
         logic [c_RES_W-1:0] w_res_in;
         logic               w_unused_hi;

         always_comb begin
            w_fmt   = decode_fmt(inst_in, c_XLEN64);
            w_imm64 = extend_imm(inst_in, w_fmt, c_XLEN64);
         end

         assign w_res_in    = {w_imm64[XLEN-1:0], w_fmt, (w_fmt == FMT_ILL), tag_in};
         assign w_unused_hi = ^w_imm64;

         pipe_stage_reg #(
            .WIDTH(c_RES_W)
         ) u_s0 (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_data  (w_res_in),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data (w_res_out)
         );
      end else begin : g_two_stage
         imm_fmt_t           w_fmt_in;
         logic [c_S0_W-1:0]  w_s0_in;
         logic [c_S0_W-1:0]  w_s0_data;
         logic               w_s0_valid;
         logic               w_s1_ready;
         logic [31:0]        w_s0_inst;
         logic [TAG_W-1:0]   w_s0_tag;
         imm_fmt_t           w_s0_fmt;
         logic [63:0]        w_imm64;
         logic [c_RES_W-1:0] w_res_in;
         logic               w_unused_hi;

         always_comb begin
            w_fmt_in = decode_fmt(inst_in, c_XLEN64);
         end

         assign w_s0_in = {inst_in, tag_in, w_fmt_in};

         pipe_stage_reg #(
            .WIDTH(c_S0_W)
         ) u_s0 (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_data  (w_s0_in),
            .out_valid(w_s0_valid),
            .out_ready(w_s1_ready),
            .out_data (w_s0_data)
         );

         assign w_s0_inst = w_s0_data[c_S0_W-1 -: 32];
         assign w_s0_tag  = w_s0_data[3 +: TAG_W];
         assign w_s0_fmt  = imm_fmt_t'(w_s0_data[2:0]);

         always_comb begin
            w_imm64 = extend_imm(w_s0_inst, w_s0_fmt, c_XLEN64);
         end

         assign w_res_in    = {w_imm64[XLEN-1:0], w_s0_fmt, (w_s0_fmt == FMT_ILL), w_s0_tag};
         assign w_unused_hi = ^w_imm64;

         pipe_stage_reg #(
            .WIDTH(c_RES_W)
         ) u_s1 (
            .clk      (clk),
            .rst      (rst),
            .in_valid (w_s0_valid),
            .in_ready (w_s1_ready),
            .in_data  (w_res_in),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data (w_res_out)
         );
      end
   endgenerate

   assign imm_out     = w_res_out[c_RES_W-1 -: XLEN];
   assign fmt_out     = w_res_out[TAG_W+1 +: 3];
   assign illegal_out = w_res_out[TAG_W];
   assign tag_out     = w_res_out[TAG_W-1:0];

endmodule

`default_nettype wire
